// File: rtl/multi_uart_pkg.sv
// Shared types and helpers for the N-channel UART array.
package multi_uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  // Widest supported data word; narrower words are zero-extended for parity.
  localparam int unsigned MAX_DATA_BITS = 9;
  // Start plus stop bit surrounding the data and optional parity bit.
  localparam int unsigned FRAME_OVERHEAD = 2;

  // Bit times per frame: start + data + parity + stop.
  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity_en);
    return FRAME_OVERHEAD + data_bits + parity_en;
  endfunction

  // Parity bit that makes the total number of ones even (odd when odd=1).
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                       input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_chan_n.sv
// One UART channel: valid/ready TX FSM and mid-bit sampling RX FSM, both
// paced by the shared oversampling tick.
//
// TX state | meaning
// IDLE     | line high, ready for a word
// START    | driving start bit (0)
// DATA     | shifting data out LSB first
// PARITY   | driving parity bit
// STOP     | driving stop bit (1)
//
// RX state  | meaning
// IDLE      | waiting for a low line on a tick
// START     | counting to mid start bit to confirm it
// DATA      | sampling data bits at mid-bit
// PARITY    | sampling parity bit
// STOP      | sampling stop bit, delivering the word
// WAIT_IDLE | break/framing error, waiting for line high
module uart_chan_n
  import multi_uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int BI_W = $clog2(DATA_BITS + 1);
  localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] HALF_LAST = OS_W'(OVERSAMPLE / 2 - 2);
  localparam logic [BI_W-1:0] BIT_LAST  = BI_W'(DATA_BITS - 1);
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  localparam logic PAR_ON  = (PARITY_EN != 0);

  tx_state_t tx_st_q, tx_st_d;
  logic [OS_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [BI_W-1:0] tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic tx_par_q, tx_par_d;
  logic tx_bit_end;

  rx_state_t rx_st_q, rx_st_d;
  logic [OS_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [BI_W-1:0] rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic rx_par_q, rx_par_d;
  logic rx_meta_q, rx_sync_q;
  logic rx_valid_q, rx_valid_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic rx_fe_q, rx_fe_d, rx_pe_q, rx_pe_d;

  // Ready only while idle and out of reset.
  assign tx_ready = (tx_st_q == TX_IDLE) && rst;

  // TX next state, bit timing and serial output.
  always_comb begin
    tx_st_d    = tx_st_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    tx         = 1'b1;
    tx_bit_end = tick && (tx_cnt_q == OS_LAST);
    if (tick) tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + OS_W'(1);
    unique case (tx_st_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (tx_valid && tx_ready) begin
          tx_st_d  = TX_START;
          tx_sh_d  = tx_data;
          tx_par_d = calc_parity(MAX_DATA_BITS'(tx_data), PAR_ODD);
          tx_bit_d = '0;
        end
      end
      TX_START: begin
        tx = 1'b0;
        if (tx_bit_end) tx_st_d = TX_DATA;
      end
      TX_DATA: begin
        tx = tx_sh_q[0];
        if (tx_bit_end) begin
          tx_sh_d = tx_sh_q >> 1;
          if (tx_bit_q == BIT_LAST) tx_st_d = PAR_ON ? TX_PARITY : TX_STOP;
          else tx_bit_d = tx_bit_q + BI_W'(1);
        end
      end
      TX_PARITY: begin
        tx = tx_par_q;
        if (tx_bit_end) tx_st_d = TX_STOP;
      end
      TX_STOP: begin
        if (tx_bit_end) tx_st_d = TX_IDLE;
      end
      default: tx_st_d = TX_IDLE;
    endcase
  end

  // RX next state: start confirmation, mid-bit sampling, word delivery.
  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_par_d   = rx_par_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    rx_fe_d    = rx_fe_q;
    rx_pe_d    = rx_pe_q;
    unique case (rx_st_q)
      RX_IDLE: begin
        if (tick && !rx_sync_q) begin
          rx_st_d  = RX_START;
          rx_cnt_d = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_d = '0;
            rx_bit_d = '0;
            rx_st_d  = rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_d = rx_cnt_q + OS_W'(1);
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (rx_cnt_q == OS_LAST) begin
            rx_cnt_d = '0;
            rx_sh_d  = {rx_sync_q, rx_sh_q[DATA_BITS-1:1]};
            if (rx_bit_q == BIT_LAST) rx_st_d = PAR_ON ? RX_PARITY : RX_STOP;
            else rx_bit_d = rx_bit_q + BI_W'(1);
          end else begin
            rx_cnt_d = rx_cnt_q + OS_W'(1);
          end
        end
      end
      RX_PARITY: begin
        if (tick) begin
          if (rx_cnt_q == OS_LAST) begin
            rx_cnt_d = '0;
            rx_par_d = rx_sync_q;
            rx_st_d  = RX_STOP;
          end else begin
            rx_cnt_d = rx_cnt_q + OS_W'(1);
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (rx_cnt_q == OS_LAST) begin
            rx_cnt_d   = '0;
            rx_valid_d = 1'b1;
            rx_data_d  = rx_sh_q;
            rx_fe_d    = !rx_sync_q;
            rx_pe_d    = PAR_ON &&
                         (rx_par_q != calc_parity(MAX_DATA_BITS'(rx_sh_q), PAR_ODD));
            rx_st_d    = rx_sync_q ? RX_IDLE : RX_WAIT_IDLE;
          end else begin
            rx_cnt_d = rx_cnt_q + OS_W'(1);
          end
        end
      end
      RX_WAIT_IDLE: begin
        if (rx_sync_q) rx_st_d = RX_IDLE;
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // State, synchroniser and output registers; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_st_q    <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      rx_st_q    <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_par_q   <= 1'b0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_fe_q    <= 1'b0;
      rx_pe_q    <= 1'b0;
    end else begin
      tx_st_q    <= tx_st_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_par_q   <= rx_par_d;
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_fe_q    <= rx_fe_d;
      rx_pe_q    <= rx_pe_d;
    end
  end

  assign rx_valid      = rx_valid_q;
  assign rx_data       = rx_data_q;
  assign rx_frame_err  = rx_fe_q;
  assign rx_parity_err = rx_pe_q;

endmodule

// File: rtl/multi_uart_nch.sv
// N-channel UART array: one shared runtime-divisor tick generator feeding
// NUM_CH independent channels.
module multi_uart_nch
  import multi_uart_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [NUM_CH-1:0]             rx,
  input  logic [NUM_CH-1:0]             tx_valid,
  input  logic [NUM_CH*DATA_BITS-1:0]   tx_data,
  output logic [NUM_CH-1:0]             tx_ready,
  output logic [NUM_CH-1:0]             tx,
  output logic [NUM_CH-1:0]             rx_valid,
  output logic [NUM_CH*DATA_BITS-1:0]   rx_data,
  output logic [NUM_CH-1:0]             rx_frame_err,
  output logic [NUM_CH-1:0]             rx_parity_err
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic tick;

  // Tick when the counter reaches the divisor; >= lets a lowered divisor act at once.
  always_comb begin
    tick      = (div_cnt_q >= baud_div);
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
  end

  // Divider counter register.
  always_ff @(posedge clk) begin
    if (!rst) div_cnt_q <= '0;
    else      div_cnt_q <= div_cnt_d;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    uart_chan_n #(
      .DATA_BITS (DATA_BITS),
      .OVERSAMPLE(OVERSAMPLE),
      .PARITY_EN (PARITY_EN),
      .PARITY_ODD(PARITY_ODD)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick),
      .rx           (rx[g]),
      .tx_valid     (tx_valid[g]),
      .tx_data      (tx_data[g*DATA_BITS +: DATA_BITS]),
      .tx_ready     (tx_ready[g]),
      .tx           (tx[g]),
      .rx_valid     (rx_valid[g]),
      .rx_data      (rx_data[g*DATA_BITS +: DATA_BITS]),
      .rx_frame_err (rx_frame_err[g]),
      .rx_parity_err(rx_parity_err[g])
    );
  end

endmodule

// File: tb/tb_multi_uart_nch.sv
// Directed bench for multi_uart_nch: default 4-channel array plus a
// single-channel even-parity instance.
module tb_multi_uart_nch;

  logic clk;
  logic rst;
  logic [15:0] baud_div;
  logic loop_en;
  logic [3:0] rx_drv, rx_bus, tx_valid, tx_ready, tx, rx_valid, fe, pe;
  logic [31:0] tx_data, rx_data;

  logic p_rx, p_tx_valid, p_tx_ready, p_tx, p_rx_valid, p_fe, p_pe;
  logic [7:0] p_tx_data, p_rx_data;

  int total, bad;
  int rv_cnt [4];
  logic [7:0] cap_data [4];
  logic cap_fe [4];
  logic cap_pe [4];
  int p_cnt;

  assign rx_bus = loop_en ? tx : rx_drv;

  multi_uart_nch dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .rx(rx_bus),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .tx(tx),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_frame_err(fe), .rx_parity_err(pe)
  );

  multi_uart_nch #(.NUM_CH(1), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .rst(rst), .baud_div(baud_div), .rx(p_rx),
    .tx_valid(p_tx_valid), .tx_data(p_tx_data), .tx_ready(p_tx_ready), .tx(p_tx),
    .rx_valid(p_rx_valid), .rx_data(p_rx_data), .rx_frame_err(p_fe), .rx_parity_err(p_pe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Receive-side monitor: counts rx_valid pulses and captures what came with them.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rx_valid[i]) begin
        rv_cnt[i]   <= rv_cnt[i] + 1;
        cap_data[i] <= rx_data[i*8 +: 8];
        cap_fe[i]   <= fe[i];
        cap_pe[i]   <= pe[i];
      end
    end
    if (p_rx_valid) p_cnt <= p_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input int ch, input logic v, input int n);
    if (ch < 0) p_rx = v;
    else rx_drv[ch] = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int ch, input logic [7:0] d, input logic use_par,
                            input logic par, input logic stop);
    drive_bit(ch, 1'b0, 16);
    for (int k = 0; k < 8; k++) drive_bit(ch, d[k], 16);
    if (use_par) drive_bit(ch, par, 16);
    drive_bit(ch, stop, 16);
  endtask

  initial begin
    logic [9:0]  exp_a5;
    logic [31:0] exp_lb;
    logic [10:0] pbits;
    int mism, low, base, k;
    int base_lb [4];

    rst = 1'b0; baud_div = 16'd0; loop_en = 1'b0; rx_drv = 4'hF;
    tx_valid = 4'h0; tx_data = 32'h0;
    p_rx = 1'b1; p_tx_valid = 1'b0; p_tx_data = 8'h00;
    repeat (3) @(negedge clk);

    check("reset_tx", 32'(tx), 32'hF);
    check("reset_tx_ready", 32'(tx_ready), 32'h0);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_rx_data", rx_data, 32'h0);
    check("reset_err_flags", {24'h0, fe, pe}, 32'h0);

    rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(tx_ready), 32'hF);
    check("p_ready_after_reset", 32'(p_tx_ready), 32'h1);

    // TX framing of 0xA5 on channel 0
    exp_a5 = 10'b1_10100101_0;
    tx_data[7:0] = 8'hA5;
    tx_valid[0] = 1'b1;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    mism = 0; low = 0;
    for (int j = 0; j < 160; j++) begin
      if (tx[0] !== exp_a5[j/16]) mism++;
      if (!tx_ready[0]) low++;
      @(negedge clk);
    end
    check("tx_a5_waveform_mismatches", 32'(mism), 32'h0);
    check("tx_a5_ready_low_clks", 32'(low), 32'd160);
    check("tx_a5_ready_after", 32'(tx_ready[0]), 32'h1);
    check("tx_a5_line_idle_after", 32'(tx[0]), 32'h1);

    // Loopback on all four channels at once
    exp_lb = {8'hA5, 8'h3C, 8'hFF, 8'h00};
    for (int i = 0; i < 4; i++) base_lb[i] = rv_cnt[i];
    loop_en = 1'b1;
    tx_data = exp_lb;
    tx_valid = 4'hF;
    @(negedge clk);
    tx_valid = 4'h0;
    repeat (200) @(negedge clk);
    loop_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lb_count_ch%0d", i), 32'(rv_cnt[i] - base_lb[i]), 32'd1);
      check($sformatf("lb_data_ch%0d", i), 32'(cap_data[i]), 32'(exp_lb[i*8 +: 8]));
      check($sformatf("lb_frame_err_ch%0d", i), 32'(cap_fe[i]), 32'h0);
      check($sformatf("lb_parity_err_ch%0d", i), 32'(cap_pe[i]), 32'h0);
    end

    // Framing error followed by a held break on channel 1
    base = rv_cnt[1];
    send_frame(1, 8'h55, 1'b0, 1'b0, 1'b0);
    drive_bit(1, 1'b0, 48);
    check("brk_count", 32'(rv_cnt[1] - base), 32'd1);
    check("brk_data", 32'(cap_data[1]), 32'h55);
    check("brk_frame_err", 32'(cap_fe[1]), 32'h1);
    check("brk_parity_err", 32'(cap_pe[1]), 32'h0);
    drive_bit(1, 1'b1, 32);
    check("brk_no_extra_valid", 32'(rv_cnt[1] - base), 32'd1);
    send_frame(1, 8'h3C, 1'b0, 1'b0, 1'b1);
    drive_bit(1, 1'b1, 20);
    check("post_brk_count", 32'(rv_cnt[1] - base), 32'd2);
    check("post_brk_data", 32'(cap_data[1]), 32'h3C);
    check("post_brk_frame_err", 32'(cap_fe[1]), 32'h0);

    // False start on channel 2, then a real frame
    base = rv_cnt[2];
    drive_bit(2, 1'b0, 4);
    drive_bit(2, 1'b1, 40);
    check("false_start_no_valid", 32'(rv_cnt[2] - base), 32'd0);
    send_frame(2, 8'h81, 1'b0, 1'b0, 1'b1);
    drive_bit(2, 1'b1, 20);
    check("after_false_count", 32'(rv_cnt[2] - base), 32'd1);
    check("after_false_data", 32'(cap_data[2]), 32'h81);
    check("after_false_frame_err", 32'(cap_fe[2]), 32'h0);

    // Even parity: TX of 0x07 carries parity 1
    p_tx_data = 8'h07;
    p_tx_valid = 1'b1;
    @(negedge clk);
    p_tx_valid = 1'b0;
    pbits = '0;
    for (int j = 0; j < 176; j++) begin
      if (j % 16 == 8) pbits[j/16] = p_tx;
      @(negedge clk);
    end
    check("par_tx_parity_bit", 32'(pbits[9]), 32'h1);
    check("par_tx_frame", 32'(pbits), 32'(11'b11_00000111_0));
    check("par_tx_ready_after", 32'(p_tx_ready), 32'h1);

    // Even parity: RX with wrong then right parity bit
    base = p_cnt;
    send_frame(-1, 8'h07, 1'b1, 1'b0, 1'b1);
    drive_bit(-1, 1'b1, 20);
    check("par_rx_count", 32'(p_cnt - base), 32'd1);
    check("par_rx_data", 32'(p_rx_data), 32'h07);
    check("par_rx_parity_err", 32'(p_pe), 32'h1);
    check("par_rx_frame_err", 32'(p_fe), 32'h0);
    send_frame(-1, 8'h07, 1'b1, 1'b1, 1'b1);
    drive_bit(-1, 1'b1, 20);
    check("par_rx_good_count", 32'(p_cnt - base), 32'd2);
    check("par_rx_good_parity_err", 32'(p_pe), 32'h0);

    // Reset in the middle of a TX frame
    tx_data[7:0] = 8'h00;
    tx_valid[0] = 1'b1;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    repeat (40) @(negedge clk);
    check("mid_frame_tx_low", 32'(tx[0]), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_abort_tx_high", 32'(tx[0]), 32'h1);
    check("reset_abort_ready_low", 32'(tx_ready[0]), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("release_ready", 32'(tx_ready), 32'hF);
    check("release_tx_idle", 32'(tx), 32'hF);

    // Divider: baud_div=3 stretches the frame to 640 clks (tick phase +/-3)
    baud_div = 16'd3;
    tx_data[7:0] = 8'hA5;
    tx_valid[0] = 1'b1;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    low = 0; k = 0;
    while (!tx_ready[0] && k < 2000) begin
      low++;
      k++;
      @(negedge clk);
    end
    check("div3_frame_len_in_range", 32'((low >= 637) && (low <= 640)), 32'h1);
    check("div3_tx_idle_after", 32'(tx[0]), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_uart_nch.md
Name: multi_uart_nch

Overview:
- Parametrised N-channel UART array and the successor to the fixed two-channel top.
- One shared oversampling tick generator with a runtime divisor drives NUM_CH identical channels.
- Each channel has a valid/ready TX path and a mid-bit-sampling RX path with false-start rejection, optional parity, and framing/parity error flags.
- Sits between the host logic and the external serial pins.

Parameters:
- NUM_CH, 4, number of independent channels (1..16)
- DATA_BITS, 8, data bits per frame (5..9)
- OVERSAMPLE, 16, ticks per bit time (even, >=4)
- DIV_W, 16, width of baud_div
- PARITY_EN, 0, 1 = append/check one parity bit after data
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset
- baud_div  input  DIV_W  tick period minus one, in clk cycles
- rx  input  NUM_CH  serial inputs, asynchronous, idle high
- tx_valid  input  NUM_CH  per-channel TX request
- tx_data  input  NUM_CH*DATA_BITS  channel i at [i*DATA_BITS +: DATA_BITS]
- tx_ready  output  NUM_CH  channel can accept a byte
- tx  output  NUM_CH  serial outputs, idle high
- rx_valid  output  NUM_CH  one-cycle pulse, frame received
- rx_data  output  NUM_CH*DATA_BITS  last received word, held until the next rx_valid
- rx_frame_err  output  NUM_CH  stop bit sampled 0; updated with rx_valid
- rx_parity_err  output  NUM_CH  parity mismatch; updated with rx_valid; always 0 when PARITY_EN=0

Behaviour:
- Reset (rst==0 at clk edge):
  - tx=all 1, tx_ready=0 while rst is low.
  - rx_valid=0, rx_data=0, both error flags=0.
  - Divider counter=0, all FSMs in IDLE, RX synchronisers=1.
  - Reset mid-frame aborts the frame immediately; tx returns high in the cycle after the reset edge.
- Tick generator:
  - Counter increments each clk.
  - When cnt>=baud_div: tick=1 and cnt<=0.
  - baud_div=0 gives a tick every clk.
  - A lowered baud_div takes effect at once via the >= compare.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - tx_ready=1 only in IDLE and out of reset.
  - Accept when tx_valid&&tx_ready: latch the word, enter START on the next cycle, tx=0 from that cycle.
  - Each bit lasts OVERSAMPLE ticks. DATA sends LSB first. PARITY is skipped if PARITY_EN=0. STOP drives tx=1 for one bit time.
  - After STOP the FSM returns to IDLE and tx_ready=1. A held tx_valid is accepted that cycle, so back-to-back frames have no extra idle.
  - tx_data and tx_valid are ignored while tx_ready=0.
- RX path: 2-flop synchroniser per channel. FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: on a tick with sync rx==0, go to START and clear the tick count.
  - START: after OVERSAMPLE/2-1 further ticks, resample. If 1 (false start), return to IDLE with no output. If 0, continue.
  - Data, parity and stop bits are sampled every OVERSAMPLE ticks thereafter, at mid-bit.
  - At the stop sample, in the same cycle:
    - rx_valid pulses for one clk.
    - rx_data loads.
    - rx_frame_err = (stop==0).
    - rx_parity_err = (received parity != computed parity).
  - Data is delivered even on error.
  - Stop==1: go to IDLE, so a new start bit half a bit later is caught.
  - Stop==0 (break or framing error): go to WAIT_IDLE, stay until sync rx==1, then go to IDLE.
- Channels are fully independent. Simultaneous activity on all channels is legal. No arbitration.
- Frame length = (1+DATA_BITS+PARITY_EN+1)*OVERSAMPLE ticks.

Decomposition:
- Package multi_uart_pkg holds:
  - tx_state_t and rx_state_t enums
  - parity helper function (XOR reduction plus PARITY_ODD)
  - FRAME_BITS localparam formula
- Sub-module uart_chan_n: one TX FSM plus one RX FSM, parameterised by DATA_BITS, OVERSAMPLE, PARITY_EN and PARITY_ODD, with a shared tick input.
- The top instantiates the tick generator inline and NUM_CH uart_chan_n instances via generate.

Test Plan:
- TX framing: defaults, baud_div=0. Pulse tx_valid[0] with 0xA5.
  - tx[0]=0 for 16 clks starting the cycle after accept.
  - Then 1,0,1,0,0,1,0,1 (16 clks each), then 1.
  - tx_ready[0] is low for exactly 160 clks.
- Loopback: tx[i]->rx[i] for all 4 channels, sending 0x00, 0xFF, 0x3C, 0xA5 simultaneously.
  - Each rx_valid pulses once with the matching rx_data.
  - No error flags set.
- Framing/break: drive rx[1] with 0x55 and stop=0, then hold low for 3 bit times.
  - rx_valid[1] with 0x55 and rx_frame_err[1]=1.
  - No further rx_valid until the line goes high and a new frame arrives.
- Parity: PARITY_EN=1, even, 0x07.
  - TX parity bit=1.
  - Inject an RX frame with parity=0: rx_parity_err=1, rx_data=0x07.
- False start: rx[2] low for 4 clks (OVERSAMPLE=16, baud_div=0) -> no rx_valid[2]. A valid 0x81 frame sent afterwards is received correctly.
- Reset/divider:
  - Assert rst mid-TX frame: tx=1 and tx_ready=1 one cycle after release.
  - With baud_div=3, a 0xA5 frame lasts 640 clks.
